// File: rtl/cordic_disp_pkg.sv
// Shared definitions for the CORDIC display path: BCD digit width,
// converter FSM state encoding and elaboration-time helper functions.
package cordic_disp_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CONV = ST_CONV,
    DONE = ST_DONE
  } state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

  // 10^n, used to check that the digit count covers the input range.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust
  import cordic_disp_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  output logic [BCD_W-1:0] digit_out
);

  // Add-3 correction applied before each shift.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_W'(5)) begin
      digit_out = digit_in + BCD_W'(3);
    end
  end

endmodule

// File: rtl/signed_to_bcd_seq.sv
// Sequential signed binary to packed BCD converter. Accepts one sample via
// valid/ready, converts the magnitude one bit per clock using shift-and-add-3,
// and holds the result plus sign until the display stage takes it.
module signed_to_bcd_seq
  import cordic_disp_pkg::*;
#(
  parameter int W        = 11,
  parameter int N_DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BCD_W*N_DIGITS-1:0] bcd_out,
  output logic                      sig_out
);

  localparam int     CNT_W   = clog2(W + 1);
  localparam int     BCD_TOT = BCD_W * N_DIGITS;
  localparam longint MAX_BCD = pow10(N_DIGITS) - 1;
  localparam longint MAX_MAG = longint'(1) << (W - 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);
  localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};

  // The digit count must be able to represent the most negative magnitude.
  if (MAX_BCD < MAX_MAG) begin : g_range_check
    $error("signed_to_bcd_seq: N_DIGITS too small for input width W");
  end

  state_t             state_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [W-1:0]       mag_reg;
  logic [BCD_TOT-1:0] bcd_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sig_reg;
  logic [BCD_TOT-1:0] bcd_out_reg;
  logic               sig_out_reg;

  logic [W-1:0]       data_mag;
  logic [BCD_TOT-1:0] bcd_adj;
  logic [BCD_TOT-1:0] bcd_next;
  logic [W-1:0]       mag_next;

  // Absolute value kept as W-bit unsigned so -2^(W-1) maps to 2^(W-1).
  assign data_mag = data_in[W-1] ? ((~data_in) + ONE_W) : data_in;

  // One add-3 cell per digit of the shift register.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_adjust
      bcd_digit_adjust u_adjust (
        .digit_in  (bcd_reg[gi*BCD_W +: BCD_W]),
        .digit_out (bcd_adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // Corrected digits and the remaining magnitude shift left as one register.
  assign {bcd_next, mag_next} = {bcd_adj, mag_reg} << 1;

  // Control FSM with the datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      mag_reg       <= '0;
      bcd_reg       <= '0;
      cnt_reg       <= '0;
      sig_reg       <= 1'b1;
      bcd_out_reg   <= '0;
      sig_out_reg   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mag_reg      <= data_mag;
            sig_reg      <= ~data_in[W-1];
            bcd_reg      <= '0;
            cnt_reg      <= CNT_LOAD;
            state_reg    <= CONV;
            in_ready_reg <= 1'b0;
          end
        end
        CONV: begin
          bcd_reg <= bcd_next;
          mag_reg <= mag_next;
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            // Publish the finished result only on the edge that enters DONE.
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            bcd_out_reg   <= bcd_next;
            sig_out_reg   <= sig_reg;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign bcd_out   = bcd_out_reg;
  assign sig_out   = sig_out_reg;

endmodule

// File: doc/signed_to_bcd_seq.md
# signed_to_bcd_seq

Sequential signed-binary-to-BCD converter that sits directly upstream of the seven-segment digit decoders. It accepts one two's-complement sample from the CORDIC result path through a valid/ready handshake. It converts the magnitude to packed BCD digits using the shift-and-add-3 (double-dabble) algorithm, one bit per clock, and holds the result and sign for the display stage. It replaces wide combinational divide/modulo chains with a small, timing-friendly iterative datapath.

## Interface
- `W`, 11: input width, two's complement.
- `N_DIGITS`, 5: number of BCD digits produced.
- Elaboration check: 10^N_DIGITS − 1 ≥ 2^(W−1). Elaboration fails otherwise.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `data_in` is valid.
- `in_ready`  out  1  block can accept a sample.
- `data_in`  in  W  signed sample.
- `out_valid`  out  1  `bcd_out`/`sig_out` hold a completed conversion.
- `out_ready`  in  1  consumer takes the result.
- `bcd_out`  out  4·N_DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- `sig_out`  out  1  1 = positive or zero, 0 = negative.

## Operation
- FSM states: IDLE, CONV, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- **IDLE:**
  - On `in_valid` && `in_ready`, the block latches magnitude `mag` = `data_in` < 0 ? −`data_in` : `data_in`.
  - `mag` is W bits unsigned, so the most negative input −2^(W−1) gives the correct magnitude 2^(W−1).
  - It latches `sig_reg` = ~`data_in`[W−1], clears the BCD shift register, loads bit counter = W, and goes to CONV.
- **CONV:**
  - Each cycle, every 4-bit digit ≥ 5 gets +3.
  - Then {bcd, mag} shifts left one bit together, and the counter decrements.
  - When the counter reaches 0 after the shift, the state becomes DONE.
- **DONE:**
  - `bcd_out` and `sig_out` are registered and stay stable while `out_valid` && !`out_ready`.
  - On `out_ready`, the state returns to IDLE. Outputs keep their last value until the next conversion completes.
- The two handshakes never overlap, because `in_ready` is low in CONV and DONE.
- `in_valid` asserted outside IDLE is ignored, and `data_in` is not sampled.
- Input zero produces `sig_out` = 1 and all-zero BCD (no negative zero).
- `bcd_out` and `sig_out` change only on the edge that enters DONE. They never show partial results.

## Timing
- Reset (async assert; deassert synchronised externally):
  - State goes to IDLE.
  - `in_ready` = 1, `out_valid` = 0, `bcd_out` = 0, `sig_out` = 1.
  - The internal counter, `mag` and the shift register are cleared.
- Latency: `out_valid` rises exactly W clock edges after the accepting edge. That is 11 cycles at the defaults.
- Throughput: one sample per W + 2 cycles when `out_ready` is held high: accept, W shifts, one DONE cycle.
- Reset during CONV or DONE aborts the conversion immediately. No result is produced, and outputs return to their reset values.
- `out_ready` held high before DONE is legal. The handshake completes on the first DONE cycle.
- There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `cordic_disp_pkg` holds:
  - `BCD_W` = 4.
  - The FSM state encoding (IDLE/CONV/DONE localparams).
  - Function `clog2` for the counter width, which is clog2(W+1).
- Sub-module `bcd_digit_adjust` is combinational. It takes a 4-bit digit in and returns digit + 3 if ≥ 5, otherwise the digit unchanged. It is instantiated N_DIGITS times via generate.
- Top level contains the FSM, counter, magnitude register and shift register. Expected size is ~150–250 lines.

## Test plan
- `data_in` = 0, `out_ready` = 1:
  - `out_valid` rises 11 cycles after accept.
  - `bcd_out` = 20'h00000, `sig_out` = 1.
- `data_in` = +1023 → `bcd_out` = 20'h01023, `sig_out` = 1. `data_in` = −1 → 20'h00001, `sig_out` = 0.
- `data_in` = −1024 (most negative) → `bcd_out` = 20'h01024, `sig_out` = 0.
- `data_in` = −735 with `out_ready` held low for 20 cycles:
  - `bcd_out` = 20'h00735 and `sig_out` = 0 stay stable, and `in_ready` stays 0.
  - A new `in_valid` with +5 during the hold is ignored.
  - After `out_ready` pulses, state returns to IDLE and `in_ready` = 1.
- `rst` asserted 5 cycles into a conversion of +999:
  - Outputs immediately go to `in_ready` = 1, `out_valid` = 0, `bcd_out` = 0, `sig_out` = 1.
  - The next sample, +42, yields 20'h00042.
- Back-to-back samples with `out_ready` tied high: 100 random values in [−1024, 1023], each checked against a reference model of the decimal digits. Spacing must be exactly 13 cycles.
